// File: rtl/argmax_collect_ctrl_if.sv
// Bundle between the argmax collection controller and its neighbours:
// the output-layer neurons, the argmax compare unit and the downstream consumer.
//
// Handshake semantics:
//   - neuron_vld[i] is accepted when in_ready=1.
//   - max_din_vld and max_idx_vld are single-cycle strobes with no back-pressure.
//   - result_valid/result_ready is a strict valid/ready pair:
//     - A transfer happens on a clock edge where both are high.
//     - Once result_valid rises, it and result_idx stay stable until that transfer.
//     - result_ready has no effect while result_valid is low.
interface argmax_collect_ctrl_if #(
  parameter int NUM_NEURON = 10,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_NEURON*DATA_WIDTH-1:0] neuron_out;
  logic [NUM_NEURON-1:0]            neuron_vld;
  logic                             in_ready;
  logic [NUM_NEURON*DATA_WIDTH-1:0] max_din;
  logic                             max_din_vld;
  logic [31:0]                      max_idx;
  logic                             max_idx_vld;
  logic [31:0]                      result_idx;
  logic                             result_valid;
  logic                             result_ready;
  logic                             busy;
  logic                             timeout_err;
  logic                             dup_err;
  logic [15:0]                      infer_count;
  logic [2:0]                       state_dbg;

  modport master (
    output neuron_out, neuron_vld, max_idx, max_idx_vld, result_ready,
    input  in_ready, max_din, max_din_vld, result_idx, result_valid,
           busy, timeout_err, dup_err, infer_count, state_dbg
  );

  modport slave (
    input  neuron_out, neuron_vld, max_idx, max_idx_vld, result_ready,
    output in_ready, max_din, max_din_vld, result_idx, result_valid,
           busy, timeout_err, dup_err, infer_count, state_dbg
  );
endinterface

// File: rtl/argmax_collect_ctrl.sv
// Collects per-neuron output-layer results into a packed vector.
// Once every neuron has reported, it launches one argmax compare.
// The returned class index is then held on a valid/ready handshake.
// Also provides a collection watchdog, sticky duplicate detection and an inference counter.
module argmax_collect_ctrl #(
  parameter int NUM_NEURON = 10,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  argmax_collect_ctrl_if.slave  bus
);
  localparam int VW   = NUM_NEURON * DATA_WIDTH;
  // Watchdog only ever needs to reach TIMEOUT-1 (it restarts on COLLECT entry).
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_LAUNCH  = 3'd2,
    S_WAIT    = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  in_rdy, busy_o, launch_o, rvalid_o;
  logic [NUM_NEURON-1:0] mask_q, accept_v, dup_v, mask_cap;
  logic                  all_in, wd_expire, abort, handshake;
  logic [VW-1:0]         buf_q;
  logic [WD_W-1:0]       wd_q;
  logic [31:0]           ridx_q;
  logic                  dup_q, tout_q;
  logic [15:0]           cnt_q;

  // Per-neuron accept/duplicate split and the mask as it stands after this cycle's captures.
  always_comb begin
    accept_v  = bus.neuron_vld & ~mask_q & {NUM_NEURON{in_rdy}};
    dup_v     = bus.neuron_vld &  mask_q & {NUM_NEURON{in_rdy}};
    mask_cap  = mask_q | accept_v;
    all_in    = &mask_cap;
    wd_expire = (TIMEOUT != 0) && (wd_q == WD_LAST);
    abort     = (state_q == S_COLLECT) && !all_in && wd_expire;
    handshake = (state_q == S_HOLD) && bus.result_ready;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: completion is tested before the watchdog so it wins a tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (|bus.neuron_vld) state_d = all_in ? S_LAUNCH : S_COLLECT;
      S_COLLECT: begin
        if (all_in)         state_d = S_LAUNCH;
        else if (wd_expire) state_d = S_IDLE;
      end
      S_LAUNCH:  state_d = S_WAIT;
      S_WAIT:    if (bus.max_idx_vld) state_d = S_HOLD;
      S_HOLD:    if (bus.result_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_rdy   = (state_q == S_IDLE) || (state_q == S_COLLECT);
    busy_o   = (state_q != S_IDLE);
    launch_o = (state_q == S_LAUNCH);
    rvalid_o = (state_q == S_HOLD);
  end

  // Datapath: buffer capture, mask, watchdog, result capture, error flags and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      buf_q  <= '0;
      wd_q   <= '0;
      ridx_q <= '0;
      dup_q  <= 1'b0;
      tout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      tout_q <= abort;
      for (int i = 0; i < NUM_NEURON; i++) begin
        if (accept_v[i])
          buf_q[i*DATA_WIDTH +: DATA_WIDTH] <= bus.neuron_out[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (abort || handshake) mask_q <= '0;
      else                    mask_q <= mask_cap;
      if (|dup_v) dup_q <= 1'b1;
      if (state_q != S_COLLECT)                      wd_q <= '0;
      else if ((TIMEOUT != 0) && !wd_expire)         wd_q <= wd_q + 1'b1;
      if ((state_q == S_WAIT) && bus.max_idx_vld)    ridx_q <= bus.max_idx;
      if (handshake)                                 cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.in_ready     = in_rdy;
  assign bus.busy         = busy_o;
  assign bus.max_din_vld  = launch_o;
  assign bus.max_din      = buf_q;
  assign bus.result_valid = rvalid_o;
  assign bus.result_idx   = ridx_q;
  assign bus.timeout_err  = tout_q;
  assign bus.dup_err      = dup_q;
  assign bus.infer_count  = cnt_q;
  assign bus.state_dbg    = state_q;
endmodule
